// File: rtl/video_reset_sequencer.sv
// Staged reset distributor: synchronises reset release and PLL lock, then frees
// each subsystem reset in order, with a soft re-sequence request.
module video_reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 256,
  parameter int SYNC_STAGES = 2,
  parameter int SOFT_HOLD   = 16
) (
  input  logic                  CLK,
  input  logic                  FABRIC_RESET_N,
  input  logic                  PLL_LOCK,
  input  logic                  SOFT_RST_REQ,
  output logic                  SOFT_RST_ACK,
  output logic [NUM_STAGES-1:0] STAGE_RESET_N,
  output logic                  SEQ_DONE,
  output logic [1:0]            DBG_STATE
);

  localparam int CW_D  = $clog2(STAGE_DELAY);
  localparam int CW_H  = $clog2(SOFT_HOLD);
  localparam int CNT_W = (CW_D > CW_H) ? CW_D : CW_H;
  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_ASSERT  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_sync_n;
  logic                   lock_s;

  // Assertion clears the chain at once; release ripples through SYNC_STAGES flops.
  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) rst_sync_q <= '0;
    else                 rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) lock_sync_q <= '0;
    else             lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], PLL_LOCK};
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;

  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  // SOFT_RST_REQ/SOFT_RST_ACK form a four-phase pair: ACK rises on the edge that
  // sees REQ, and falls only once REQ is low and SOFT_HOLD cycles have elapsed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    ack_d   = ack_q;
    if (state_q == S_ASSERT) begin
      ack_d = 1'b1;
      if (cnt_q == CNT_W'(SOFT_HOLD - 1)) begin
        if (!SOFT_RST_REQ) begin
          state_d = S_HOLD;
          ack_d   = 1'b0;
          cnt_d   = '0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (SOFT_RST_REQ) begin
      state_d = S_ASSERT;
      stage_d = '0;
      done_d  = 1'b0;
      ack_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (lock_s) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        S_RELEASE: begin
          if (!lock_s) begin
            state_d = S_HOLD;
            stage_d = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (idx_q == IDX_W'(k)) stage_d[k] = 1'b1;
            end
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d = S_HOLD;
            stage_d = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  assign STAGE_RESET_N = stage_q;
  assign SEQ_DONE      = done_q;
  assign SOFT_RST_ACK  = ack_q;
  assign DBG_STATE     = state_q;

endmodule
